// File: rtl/fsk_pkg.sv
// Shared FSK definitions: FSM states, half-period classes, default tone timing.
package fsk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } fsk_state_t;

  // CLS_SHORT/CLS_LONG encode the logic level they stand for in bit 0.
  typedef enum logic [1:0] {
    CLS_SHORT,
    CLS_LONG,
    CLS_INVALID
  } fsk_cls_t;

  // Tone half-periods shared with the modulator.
  localparam int unsigned FSK_HALF_SHORT = 32;
  localparam int unsigned FSK_HALF_LONG  = 128;

  // True when l lies within centre +/- tol.
  function automatic logic within_tol(input int unsigned l,
                                      input int unsigned centre,
                                      input int unsigned tol);
    return ((l + tol) >= centre) && (l <= (centre + tol));
  endfunction

endpackage

// File: rtl/fsk_demodulator_if.sv
// RX pin and recovered-bit outputs of the FSK demodulator.
interface fsk_demodulator_if;
  logic fsk_input;
  logic logic_output;
  logic bit_valid;
  logic locked;
  logic error;

  modport master (
    input  fsk_input,
    output logic_output,
    output bit_valid,
    output locked,
    output error
  );

  modport slave (
    output fsk_input,
    input  logic_output,
    input  bit_valid,
    input  locked,
    input  error
  );
endinterface

// File: rtl/fsk_edge_detector.sv
// Synchronises the asynchronous RX line and emits a 1-clk pulse on either edge.
// Optional FSK_GLITCH_FILTER_EN: level must be stable for 2 synced samples.
module fsk_edge_detector (
  input  logic clk,
  input  logic as_reset_n,
  input  logic i_din,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_level;
  logic w_stable;

`ifdef FSK_GLITCH_FILTER_EN
  logic r_sync3;

  // Synchroniser plus one extra stage for the stability check.
  always_ff @(posedge clk or negedge as_reset_n) begin
    if (!as_reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_stable = (r_sync2 == r_sync3);
`else
  // Two-flop synchroniser.
  always_ff @(posedge clk or negedge as_reset_n) begin
    if (!as_reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
    end
  end

  assign w_stable = 1'b1;
`endif

  assign o_edge = w_stable && (r_sync2 != r_level);

  // Accepted line level; follows the synced input only on an accepted edge.
  always_ff @(posedge clk or negedge as_reset_n) begin
    if (!as_reset_n) begin
      r_level <= 1'b0;
    end else if (o_edge) begin
      r_level <= r_sync2;
    end
  end

endmodule

// File: rtl/fsk_demodulator.sv
// FSK receiver: times half-periods between RX edges, classifies them as short
// (0) / long (1) / invalid, and tracks lock with an IDLE/MEASURE/LOCKED FSM.
// Build option: FSK_GLITCH_FILTER_EN enables the edge detector glitch filter.
module fsk_demodulator
  import fsk_pkg::*;
#(
  parameter int unsigned HALF_SHORT = FSK_HALF_SHORT,
  parameter int unsigned HALF_LONG  = FSK_HALF_LONG,
  parameter int unsigned TOL        = 8,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned CNT_W      = 20
) (
  input logic             clk,
  input logic             as_reset_n,
  fsk_demodulator_if.master bus
);

  localparam int unsigned TMO   = HALF_LONG + TOL + 1;
  localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] C_TMO  = CNT_W'(TMO);
  localparam logic [RUN_W-1:0] C_LOCK = RUN_W'(LOCK_COUNT);

  if (TOL >= (HALF_LONG - HALF_SHORT) / 2) begin : g_bad_tol
    $error("TOL must be below half the short/long separation");
  end
  if ((64'd1 << CNT_W) <= 64'(TMO)) begin : g_bad_cnt_w
    $error("CNT_W too narrow to reach the timeout count");
  end

  logic r_rst_meta;
  logic r_rst_sync;
  logic w_rst_n;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk or negedge as_reset_n) begin
    if (!as_reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  logic w_edge;

  fsk_edge_detector u_edge (
    .clk        (clk),
    .as_reset_n (w_rst_n),
    .i_din      (bus.fsk_input),
    .o_edge     (w_edge)
  );

  logic [CNT_W-1:0] r_cnt;

  // Half-period counter: 1 in the cycle after an edge, so it holds L on the next edge.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  fsk_cls_t w_cls;
  logic     w_tmo;

  // Classify the current half-period length.
  always_comb begin
    w_cls = CLS_INVALID;
    if (within_tol(32'(r_cnt), HALF_SHORT, TOL)) begin
      w_cls = CLS_SHORT;
    end else if (within_tol(32'(r_cnt), HALF_LONG, TOL)) begin
      w_cls = CLS_LONG;
    end
  end

  assign w_tmo = (r_cnt >= C_TMO);

  fsk_state_t       r_state, w_state_nxt;
  fsk_cls_t         r_prev_cls, w_prev_nxt;
  logic [RUN_W-1:0] r_run, w_run_nxt, w_run_inc;
  logic             r_logic, w_logic_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_bv, w_bv_nxt;
  logic             r_err, w_err_nxt;

  assign w_run_inc = r_run + RUN_W'(1);

  // FSM state, run tracking and registered outputs.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= IDLE;
      r_prev_cls <= CLS_INVALID;
      r_run      <= '0;
      r_logic    <= 1'b0;
      r_locked   <= 1'b0;
      r_bv       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev_cls <= w_prev_nxt;
      r_run      <= w_run_nxt;
      r_logic    <= w_logic_nxt;
      r_locked   <= w_locked_nxt;
      r_bv       <= w_bv_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Next-state and output decode; an edge landing on the timeout count wins over timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_prev_nxt   = r_prev_cls;
    w_run_nxt    = r_run;
    w_logic_nxt  = r_logic;
    w_locked_nxt = r_locked;
    w_bv_nxt     = 1'b0;
    w_err_nxt    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_edge) begin
          w_state_nxt = MEASURE;
          w_prev_nxt  = CLS_INVALID;
          w_run_nxt   = '0;
        end
      end
      MEASURE, LOCKED: begin
        if (w_edge && w_tmo) begin
          w_err_nxt    = 1'b1;
          w_state_nxt  = MEASURE;
          w_prev_nxt   = CLS_INVALID;
          w_run_nxt    = '0;
          w_locked_nxt = 1'b0;
        end else if (w_tmo) begin
          w_err_nxt    = 1'b1;
          w_state_nxt  = IDLE;
          w_run_nxt    = '0;
          w_locked_nxt = 1'b0;
        end else if (w_edge) begin
          if (w_cls == CLS_INVALID) begin
            w_err_nxt  = 1'b1;
            w_run_nxt  = '0;
            w_prev_nxt = CLS_INVALID;
          end else if (r_state == MEASURE) begin
            w_run_nxt  = (w_cls == r_prev_cls) ? w_run_inc : RUN_W'(1);
            w_prev_nxt = w_cls;
            if (w_run_nxt == C_LOCK) begin
              w_state_nxt  = LOCKED;
              w_locked_nxt = 1'b1;
              w_logic_nxt  = (w_cls == CLS_LONG);
              w_bv_nxt     = 1'b1;
              w_run_nxt    = '0;
            end
          end else if ((w_cls == CLS_LONG) == r_logic) begin
            w_bv_nxt  = 1'b1;
            w_run_nxt = '0;
          end else if (w_run_inc == C_LOCK) begin
            w_logic_nxt = ~r_logic;
            w_bv_nxt    = 1'b1;
            w_run_nxt   = '0;
          end else begin
            w_run_nxt = w_run_inc;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.logic_output = r_logic;
  assign bus.bit_valid    = r_bv;
  assign bus.locked       = r_locked;
  assign bus.error        = r_err;

endmodule

// File: tb/tb_fsk_demodulator.sv
// Self-checking bench for fsk_demodulator: directed vector table, hand-written
// corner sequences, and randomized half-period streams against a reference model.
module tb_fsk_demodulator;

  localparam int HS   = 32;
  localparam int HL   = 128;
  localparam int TOL  = 8;
  localparam int LOCK = 2;
  localparam int TMO  = HL + TOL + 1;

  logic clk = 1'b0;
  logic as_reset_n = 1'b0;
  logic fsk_in = 1'b0;

  fsk_demodulator_if bus ();
  assign bus.fsk_input = fsk_in;

  fsk_demodulator #(
    .HALF_SHORT (HS),
    .HALF_LONG  (HL),
    .TOL        (TOL),
    .LOCK_COUNT (LOCK),
    .CNT_W      (20)
  ) dut (
    .clk        (clk),
    .as_reset_n (as_reset_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_both = 0;
  int w_bv, w_err, w_bv_idx, w_err_idx;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Toggle the line (optionally), then observe n cycles; glitch>0 inserts a 1-clk pulse.
  task automatic run_half(input int n, input bit tog, input int glitch);
    if (tog) fsk_in = ~fsk_in;
    w_bv = 0; w_err = 0; w_bv_idx = -1; w_err_idx = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bus.bit_valid) begin w_bv++; if (w_bv_idx < 0) w_bv_idx = i; end
      if (bus.error) begin w_err++; if (w_err_idx < 0) w_err_idx = i; end
      if (bus.bit_valid && bus.error) n_both++;
      if (glitch > 0 && (i == glitch || i == glitch + 1)) fsk_in = ~fsk_in;
    end
  endtask

  task automatic do_reset();
    as_reset_n = 1'b0;
    fsk_in = 1'b0;
    repeat (3) @(negedge clk);
    as_reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Reference model, stepped once per line edge.
  int m_mode;   // 0 idle, 1 measuring, 2 locked
  int m_run, m_prev, m_out, m_lock;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int cls_of(input int l);
    if (iabs(l - HS) <= TOL) return 0;
    if (iabs(l - HL) <= TOL) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_prev = -1; m_out = 0; m_lock = 0;
  endtask

  // l_prev: half-period ended by this edge; n_now: time until the next edge.
  task automatic model_step(input int l_prev, input int n_now, output int e_bv, output int e_err);
    int c;
    e_bv = 0; e_err = 0;
    if (m_mode == 0) begin
      m_mode = 1; m_run = 0; m_prev = -1;
    end else if (l_prev >= TMO) begin
      e_err = 1; m_mode = 1; m_run = 0; m_prev = -1; m_lock = 0;
    end else begin
      c = cls_of(l_prev);
      if (c < 0) begin
        e_err = 1; m_run = 0; m_prev = -1;
      end else if (m_mode == 1) begin
        m_run = (c == m_prev) ? m_run + 1 : 1;
        m_prev = c;
        if (m_run == LOCK) begin
          m_mode = 2; m_lock = 1; m_out = c; e_bv = 1; m_run = 0;
        end
      end else if (c == m_out) begin
        e_bv = 1; m_run = 0;
      end else begin
        m_run++;
        if (m_run == LOCK) begin m_out = 1 - m_out; e_bv = 1; m_run = 0; end
      end
    end
    if (n_now > TMO && m_mode != 0) begin
      e_err++; m_mode = 0; m_lock = 0;
    end
  endtask

  typedef struct {
    int len; bit tog; int bv; int err; int lvl; int lck;
  } vec_t;

  vec_t tbl [24];

  initial begin
    int bad, e_bv, e_err, prev_len, n;
    int opts [13];

    tbl = '{
      '{32, 1, 0, 0, 0, 0}, '{32, 1, 0, 0, 0, 0}, '{32, 1, 1, 0, 0, 1}, '{32, 1, 1, 0, 0, 1},
      '{32, 1, 1, 0, 0, 1}, '{80, 1, 1, 0, 0, 1}, '{128, 1, 0, 1, 0, 1}, '{128, 1, 0, 0, 0, 1},
      '{128, 1, 1, 0, 1, 1}, '{128, 1, 1, 0, 1, 1}, '{32, 1, 1, 0, 1, 1}, '{32, 1, 0, 0, 1, 1},
      '{32, 1, 1, 0, 0, 1}, '{60, 1, 1, 0, 0, 1}, '{32, 1, 0, 1, 0, 1}, '{32, 1, 1, 0, 0, 1},
      '{200, 1, 1, 1, 0, 0}, '{200, 0, 0, 0, 0, 0}, '{32, 1, 0, 0, 0, 0}, '{32, 1, 0, 0, 0, 0},
      '{137, 1, 1, 0, 0, 1}, '{32, 1, 0, 1, 0, 0}, '{32, 1, 0, 0, 0, 0}, '{32, 1, 1, 0, 0, 1}
    };
    opts = '{23, 24, 32, 40, 41, 60, 80, 119, 120, 128, 136, 137, 200};

    // Reset held while the line toggles: outputs stay 0.
    bad = 0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) fsk_in = ~fsk_in;
      @(negedge clk);
      if (bus.logic_output || bus.bit_valid || bus.locked || bus.error) bad++;
    end
    chk("outputs under reset", bad, 0);
    fsk_in = 1'b1;
    as_reset_n = 1'b1;
    run_half(30, 0, 0);
    chk("no error after mid-toggle release", w_err, 0);
    chk("not locked after release", w_bv + int'(bus.locked), 0);

    // Directed table.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      run_half(tbl[i].len, tbl[i].tog, 0);
      chk($sformatf("vec%0d bit_valid", i), w_bv, tbl[i].bv);
      chk($sformatf("vec%0d error", i), w_err, tbl[i].err);
      chk($sformatf("vec%0d logic_output", i), int'(bus.logic_output), tbl[i].lvl);
      chk($sformatf("vec%0d locked", i), int'(bus.locked), tbl[i].lck);
      if (i == 16) chk("timeout delay after last edge", w_err_idx - w_bv_idx, TMO);
    end

    // Randomized half-period stream against the model.
    do_reset();
    model_reset();
    prev_len = 0;
    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 7) n = HS;
      else if (r < 14) n = HL;
      else n = opts[$urandom_range(0, 12)];
      model_step(prev_len, n, e_bv, e_err);
      prev_len = n;
      run_half(n, 1, 0);
      chk($sformatf("rnd%0d len%0d bit_valid", i, n), w_bv, e_bv);
      chk($sformatf("rnd%0d len%0d error", i, n), w_err, e_err);
      chk($sformatf("rnd%0d len%0d logic_output", i, n), int'(bus.logic_output), m_out);
      chk($sformatf("rnd%0d len%0d locked", i, n), int'(bus.locked), m_lock);
    end

    // Async reset mid-lock, then re-lock after 1 + LOCK half-periods.
    do_reset();
    repeat (3) run_half(HS, 1, 0);
    chk("locked before reset", int'(bus.locked), 1);
    run_half(10, 1, 0);
    as_reset_n = 1'b0;
    #1;
    chk("reset logic_output", int'(bus.logic_output), 0);
    chk("reset bit_valid", int'(bus.bit_valid), 0);
    chk("reset locked", int'(bus.locked), 0);
    chk("reset error", int'(bus.error), 0);
    fsk_in = 1'b0;
    repeat (2) @(negedge clk);
    as_reset_n = 1'b1;
    repeat (5) @(negedge clk);
    run_half(HS, 1, 0);
    run_half(HS, 1, 0);
    chk("relock not yet", int'(bus.locked), 0);
    run_half(HS, 1, 0);
    chk("relock locked", int'(bus.locked), 1);
    chk("relock bit_valid", w_bv, 1);

    // 1-clk glitch while locked on the short tone.
    run_half(HS, 1, 10);
`ifdef FSK_GLITCH_FILTER_EN
    chk("glitch win1 error", w_err, 0);
    chk("glitch win1 bit_valid", w_bv, 1);
    run_half(HS, 1, 0);
    chk("glitch win2 error", w_err, 0);
    chk("glitch win2 bit_valid", w_bv, 1);
`else
    chk("glitch win1 error", w_err, 2);
    chk("glitch win1 bit_valid", w_bv, 1);
    run_half(HS, 1, 0);
    chk("glitch win2 error", w_err, 1);
    chk("glitch win2 bit_valid", w_bv, 0);
`endif
    run_half(HS, 1, 0);
    chk("post-glitch bit_valid", w_bv, 1);
    chk("post-glitch locked", int'(bus.locked), 1);
    chk("post-glitch logic_output", int'(bus.logic_output), 0);

    chk("error/bit_valid overlap cycles", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
